// File: rtl/uart_rx_word_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_word_pkg
//   Shared definitions for the UART receive path: the receiver state
//   encoding, frame geometry, the bit-period floor and the helper that
//   applies it.
// ---------------------------------------------------------------------------
package uart_rx_word_pkg;

    // Frame geometry: 8N1, packed four bytes to a word.
    localparam int UART_DATA_BITS  = 8;
    localparam int UART_MIN_CLKS   = 4;
    localparam int UART_WORD_BYTES = 4;
    localparam int UART_WORD_BITS  = UART_WORD_BYTES * UART_DATA_BITS;

    // Receiver FSM states. BRK_WAIT parks the receiver after a bad stop
    // bit until the line returns high, so a held break cannot start frames.
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BRK_WAIT
    } uart_rx_state_t;

    // Effective bit period: the programmed value, never below the floor.
    function automatic logic [7:0] clamp_cpb(input logic [7:0] cpb_in,
                                             input logic [7:0] cpb_floor);
        return (cpb_in < cpb_floor) ? cpb_floor : cpb_in;
    endfunction

endpackage

// File: rtl/uart_rx_word_if.sv
// ---------------------------------------------------------------------------
// uart_rx_word_if
//   Word output channel of the UART receiver (valid/ready handshake).
//     o_word        assembled word, byte0 in bits [7:0]
//     o_word_strb   valid byte lanes of o_word
//     o_word_valid  word available, held until accepted
//     i_word_ready  consumer accepts the word
//   master: the receiver.  slave: the consumer.
// ---------------------------------------------------------------------------
interface uart_rx_word_if;
    import uart_rx_word_pkg::*;

    logic [UART_WORD_BITS-1:0]  o_word;
    logic [UART_WORD_BYTES-1:0] o_word_strb;
    logic                       o_word_valid;
    logic                       i_word_ready;

    modport master (
        output o_word,
        output o_word_strb,
        output o_word_valid,
        input  i_word_ready
    );

    modport slave (
        input  o_word,
        input  o_word_strb,
        input  o_word_valid,
        output i_word_ready
    );

endinterface

// File: rtl/uart_rx_byte.sv
// ---------------------------------------------------------------------------
// uart_rx_byte
//   8N1 byte receiver, LSB first, runtime bit period.
//   Ports:
//     clk, rst_n       clock, asynchronous active-low reset
//     i_Rx_Serial      asynchronous serial line, idles high
//     CLKS_PER_BIT     clocks per bit, latched at the start of each frame
//     o_Rx_DV          one-cycle pulse after a good byte
//     o_Rx_Byte        last good byte, held until the next one
//     o_Rx_Active      frame in progress (state != IDLE)
//     o_byte_stb       combinational strobe on the edge that accepts a byte
//     o_byte_val       byte value qualified by o_byte_stb
//     o_frame_err_stb  combinational strobe on the edge a stop bit is low
// ---------------------------------------------------------------------------
module uart_rx_byte
    import uart_rx_word_pkg::*;
#(
    parameter int MIN_CLKS = UART_MIN_CLKS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_Rx_Serial,
    input  logic [7:0] CLKS_PER_BIT,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Active,
    output logic       o_byte_stb,
    output logic [7:0] o_byte_val,
    output logic       o_frame_err_stb
);

    localparam logic [7:0] CPB_FLOOR = 8'(MIN_CLKS);

    logic [1:0]     sync_q;
    logic           rx_s;
    uart_rx_state_t state_q, state_n;
    logic [7:0]     clk_cnt_q, clk_cnt_n;
    logic [2:0]     bit_idx_q, bit_idx_n;
    logic [7:0]     cpb_q, cpb_n;
    logic [7:0]     shift_q, shift_n;
    logic           dv_q;
    logic [7:0]     byte_q;
    logic           byte_stb;
    logic           ferr_stb;
    logic [7:0]     half_m1;
    logic [7:0]     full_m1;

    // Two-flop synchroniser. It resets to the idle (high) level so that
    // leaving reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], i_Rx_Serial};
        end
    end

    assign rx_s = sync_q[1];

    // Sample points: mid start bit, then one full period per later bit.
    assign half_m1 = (cpb_q >> 1) - 8'd1;
    assign full_m1 = cpb_q - 8'd1;

    // State register plus the frame datapath, all loaded from the
    // next-state logic below.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RX_IDLE;
            clk_cnt_q <= 8'd0;
            bit_idx_q <= 3'd0;
            cpb_q     <= 8'd0;
            shift_q   <= 8'd0;
        end else begin
            state_q   <= state_n;
            clk_cnt_q <= clk_cnt_n;
            bit_idx_q <= bit_idx_n;
            cpb_q     <= cpb_n;
            shift_q   <= shift_n;
        end
    end

    // Next-state logic. The bit period is captured only on IDLE->START,
    // so reprogramming CLKS_PER_BIT mid-frame has no effect on that frame.
    always_comb begin
        state_n   = state_q;
        clk_cnt_n = clk_cnt_q;
        bit_idx_n = bit_idx_q;
        cpb_n     = cpb_q;
        shift_n   = shift_q;
        byte_stb  = 1'b0;
        ferr_stb  = 1'b0;

        unique case (state_q)
            RX_IDLE: begin
                if (!rx_s) begin
                    state_n   = RX_START;
                    clk_cnt_n = 8'd0;
                    cpb_n     = clamp_cpb(CLKS_PER_BIT, CPB_FLOOR);
                end
            end

            RX_START: begin
                if (clk_cnt_q == half_m1) begin
                    clk_cnt_n = 8'd0;
                    bit_idx_n = 3'd0;
                    // A line already back high at mid-bit was a glitch.
                    state_n   = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    clk_cnt_n = clk_cnt_q + 8'd1;
                end
            end

            RX_DATA: begin
                if (clk_cnt_q == full_m1) begin
                    clk_cnt_n          = 8'd0;
                    shift_n[bit_idx_q] = rx_s;
                    if (bit_idx_q == 3'd7) begin
                        state_n = RX_STOP;
                    end else begin
                        bit_idx_n = bit_idx_q + 3'd1;
                    end
                end else begin
                    clk_cnt_n = clk_cnt_q + 8'd1;
                end
            end

            RX_STOP: begin
                if (clk_cnt_q == full_m1) begin
                    clk_cnt_n = 8'd0;
                    if (rx_s) begin
                        byte_stb = 1'b1;
                        state_n  = RX_IDLE;
                    end else begin
                        ferr_stb = 1'b1;
                        state_n  = RX_BRK_WAIT;
                    end
                end else begin
                    clk_cnt_n = clk_cnt_q + 8'd1;
                end
            end

            RX_BRK_WAIT: begin
                if (rx_s) begin
                    state_n = RX_IDLE;
                end
            end

            default: begin
                state_n = RX_IDLE;
            end
        endcase
    end

    // Registered byte output: the valid pulse and the held byte appear the
    // cycle after the stop bit is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dv_q   <= 1'b0;
            byte_q <= 8'd0;
        end else begin
            dv_q <= byte_stb;
            if (byte_stb) begin
                byte_q <= shift_q;
            end
        end
    end

    assign o_Rx_DV         = dv_q;
    assign o_Rx_Byte       = byte_q;
    assign o_Rx_Active     = (state_q != RX_IDLE);
    assign o_byte_stb      = byte_stb;
    assign o_byte_val      = shift_q;
    assign o_frame_err_stb = ferr_stb;

endmodule

// File: rtl/uart_rx_word.sv
// ---------------------------------------------------------------------------
// uart_rx_word
//   UART receiver that packs good bytes little-endian into 32-bit words
//   with a byte strobe, delivered on a valid/ready channel.
//   Ports:
//     clk, rst_n     clock, asynchronous active-low reset
//     i_Rx_Serial    asynchronous serial line, idles high
//     CLKS_PER_BIT   clocks per bit (floored at MIN_CLKS)
//     o_Rx_DV        one-cycle pulse per good byte
//     o_Rx_Byte      last good byte
//     word_if        word channel (o_word, o_word_strb, o_word_valid,
//                    i_word_ready)
//     i_flush        push the partial word now
//     o_Rx_Active    frame in progress
//     o_frame_err    sticky: a stop bit was sampled low
//     o_overrun      sticky: a word was dropped, output register full
//     i_err_clr      clears both sticky flags
// ---------------------------------------------------------------------------
module uart_rx_word
    import uart_rx_word_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS,
    parameter int MIN_CLKS  = UART_MIN_CLKS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_Rx_Serial,
    input  logic [7:0]            CLKS_PER_BIT,
    output logic                  o_Rx_DV,
    output logic [7:0]            o_Rx_Byte,
    uart_rx_word_if.master        word_if,
    input  logic                  i_flush,
    output logic                  o_Rx_Active,
    output logic                  o_frame_err,
    output logic                  o_overrun,
    input  logic                  i_err_clr
);

    logic                       byte_stb;
    logic [7:0]                 byte_val;
    logic                       ferr_stb;

    logic [UART_WORD_BITS-1:0]  acc_q, acc_mrg;
    logic [UART_WORD_BYTES-1:0] strb_q, strb_mrg;
    logic [1:0]                 lane_q;
    logic                       push;
    logic                       out_free;

    logic [UART_WORD_BITS-1:0]  word_q;
    logic [UART_WORD_BYTES-1:0] word_strb_q;
    logic                       word_valid_q;
    logic                       frame_err_q;
    logic                       overrun_q;

    // Only 8-bit frames are implemented.
    a_data_bits: assert property (@(posedge clk) DATA_BITS == UART_DATA_BITS);

    uart_rx_byte #(
        .MIN_CLKS (MIN_CLKS)
    ) u_rx_byte (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_Rx_Serial     (i_Rx_Serial),
        .CLKS_PER_BIT    (CLKS_PER_BIT),
        .o_Rx_DV         (o_Rx_DV),
        .o_Rx_Byte       (o_Rx_Byte),
        .o_Rx_Active     (o_Rx_Active),
        .o_byte_stb      (byte_stb),
        .o_byte_val      (byte_val),
        .o_frame_err_stb (ferr_stb)
    );

    // Merge the incoming byte into the accumulator first, so a flush in
    // the same cycle as a byte carries that byte in a single push.
    always_comb begin
        acc_mrg  = acc_q;
        strb_mrg = strb_q;
        if (byte_stb) begin
            acc_mrg[{lane_q, 3'b000} +: 8] = byte_val;
            strb_mrg[lane_q]               = 1'b1;
        end
        push     = (byte_stb && (lane_q == 2'd3)) ||
                   (i_flush && (strb_mrg != '0));
        out_free = !word_valid_q || word_if.i_word_ready;
    end

    // Packer and output register. A push always empties the accumulator;
    // it reaches the output only if the register is free or being
    // accepted this cycle, otherwise the word is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q        <= '0;
            strb_q       <= '0;
            lane_q       <= 2'd0;
            word_q       <= '0;
            word_strb_q  <= '0;
            word_valid_q <= 1'b0;
        end else begin
            if (push) begin
                acc_q  <= '0;
                strb_q <= '0;
                lane_q <= 2'd0;
                if (out_free) begin
                    word_q       <= acc_mrg;
                    word_strb_q  <= strb_mrg;
                    word_valid_q <= 1'b1;
                end
            end else begin
                acc_q  <= acc_mrg;
                strb_q <= strb_mrg;
                if (byte_stb) begin
                    lane_q <= lane_q + 2'd1;
                end
                if (word_valid_q && word_if.i_word_ready) begin
                    word_valid_q <= 1'b0;
                end
            end
        end
    end

    // Sticky error flags; a set event in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (ferr_stb) begin
                frame_err_q <= 1'b1;
            end else if (i_err_clr) begin
                frame_err_q <= 1'b0;
            end
            if (push && !out_free) begin
                overrun_q <= 1'b1;
            end else if (i_err_clr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign word_if.o_word       = word_q;
    assign word_if.o_word_strb  = word_strb_q;
    assign word_if.o_word_valid = word_valid_q;
    assign o_frame_err          = frame_err_q;
    assign o_overrun            = overrun_q;

endmodule

// File: tb/tb_uart_rx_word.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_word
//   Self-checking bench for uart_rx_word. Inputs change 2 ns after the
//   rising edge; a negedge monitor pops expected bytes/words from
//   scoreboard queues as the DUT produces them.
// ---------------------------------------------------------------------------
module tb_uart_rx_word;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_Rx_Serial;
    logic [7:0] CLKS_PER_BIT;
    logic       o_Rx_DV;
    logic [7:0] o_Rx_Byte;
    logic       i_flush;
    logic       o_Rx_Active;
    logic       o_frame_err;
    logic       o_overrun;
    logic       i_err_clr;

    uart_rx_word_if word_if ();

    uart_rx_word dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_Rx_Serial  (i_Rx_Serial),
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .o_Rx_DV      (o_Rx_DV),
        .o_Rx_Byte    (o_Rx_Byte),
        .word_if      (word_if),
        .i_flush      (i_flush),
        .o_Rx_Active  (o_Rx_Active),
        .o_frame_err  (o_frame_err),
        .o_overrun    (o_overrun),
        .i_err_clr    (i_err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        logic [3:0]  strb;
    } word_exp_t;

    typedef struct {
        logic [7:0] data;
        logic [7:0] cpb_in;
        int         cpb_eff;
        bit         mid_change;
        logic [7:0] cpb_mid;
    } vec_t;

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  exp_bytes[$];
    word_exp_t   exp_words[$];
    logic [31:0] m_acc;
    logic [3:0]  m_strb;
    int          m_lane;
    vec_t        vecs[4];

    // Compare one value and report it.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        total++;
        if (actual !== required) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
        end
    endtask

    task automatic failUnexpected(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s actual=output required=none", name);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Drive one 8N1 frame on the line with the given bit period.
    task automatic sendFrame(input logic [7:0] b, input logic stop_bit,
                             input int cpb);
        i_Rx_Serial = 1'b0;
        tick(cpb);
        for (int i = 0; i < 8; i++) begin
            i_Rx_Serial = b[i];
            tick(cpb);
        end
        i_Rx_Serial = stop_bit;
        tick(cpb);
    endtask

    task automatic modelPush();
        exp_words.push_back('{word: m_acc, strb: m_strb});
        m_acc  = '0;
        m_strb = '0;
        m_lane = 0;
    endtask

    task automatic modelByte(input logic [7:0] b);
        exp_bytes.push_back(b);
        m_acc[8*m_lane +: 8] = b;
        m_strb[m_lane]       = 1'b1;
        if (m_lane == 3) modelPush();
        else m_lane++;
    endtask

    task automatic sendByte(input logic [7:0] b);
        modelByte(b);
        sendFrame(b, 1'b1, 10);
        tick(2);
    endtask

    task automatic flushPulse();
        i_flush = 1'b1;
        tick(1);
        i_flush = 1'b0;
        if (m_strb != 4'b0) modelPush();
        tick(2);
    endtask

    // Apply one table entry: program the bit period, send the byte,
    // optionally reprogram CLKS_PER_BIT during the frame.
    task automatic applyStimulus(input vec_t v);
        CLKS_PER_BIT = v.cpb_in;
        tick(2);
        modelByte(v.data);
        fork
            sendFrame(v.data, 1'b1, v.cpb_eff);
            begin
                if (v.mid_change) begin
                    tick(v.cpb_eff * 3);
                    CLKS_PER_BIT = v.cpb_mid;
                end
            end
        join
        tick(2);
        checkOutput("table_rx_byte", {24'd0, o_Rx_Byte}, {24'd0, v.data});
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (o_Rx_DV) begin
            if (exp_bytes.size() == 0) begin
                failUnexpected("rx_dv_unexpected");
            end else begin
                logic [7:0] eb;
                eb = exp_bytes.pop_front();
                checkOutput("rx_byte", {24'd0, o_Rx_Byte}, {24'd0, eb});
            end
        end
        if (word_if.o_word_valid && word_if.i_word_ready) begin
            if (exp_words.size() == 0) begin
                failUnexpected("word_unexpected");
            end else begin
                word_exp_t ew;
                ew = exp_words.pop_front();
                checkOutput("word", word_if.o_word, ew.word);
                checkOutput("word_strb", {28'd0, word_if.o_word_strb}, {28'd0, ew.strb});
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{data: 8'h11, cpb_in: 8'd10, cpb_eff: 10, mid_change: 1'b0, cpb_mid: 8'd0};
        vecs[1] = '{data: 8'h22, cpb_in: 8'd16, cpb_eff: 16, mid_change: 1'b0, cpb_mid: 8'd0};
        vecs[2] = '{data: 8'h33, cpb_in: 8'd3,  cpb_eff: 4,  mid_change: 1'b0, cpb_mid: 8'd0};
        vecs[3] = '{data: 8'h44, cpb_in: 8'd0,  cpb_eff: 4,  mid_change: 1'b1, cpb_mid: 8'd20};

        m_acc  = '0;
        m_strb = '0;
        m_lane = 0;
        rst_n                = 1'b0;
        i_Rx_Serial          = 1'b1;
        CLKS_PER_BIT         = 8'd10;
        word_if.i_word_ready = 1'b1;
        i_flush              = 1'b0;
        i_err_clr            = 1'b0;
        tick(3);

        checkOutput("rst_dv",      {31'd0, o_Rx_DV}, 32'd0);
        checkOutput("rst_byte",    {24'd0, o_Rx_Byte}, 32'd0);
        checkOutput("rst_word",    word_if.o_word, 32'd0);
        checkOutput("rst_strb",    {28'd0, word_if.o_word_strb}, 32'd0);
        checkOutput("rst_valid",   {31'd0, word_if.o_word_valid}, 32'd0);
        checkOutput("rst_active",  {31'd0, o_Rx_Active}, 32'd0);
        checkOutput("rst_ferr",    {31'd0, o_frame_err}, 32'd0);
        checkOutput("rst_overrun", {31'd0, o_overrun}, 32'd0);
        rst_n = 1'b1;
        tick(5);

        $display("[TB] single byte 0xA5");
        sendByte(8'hA5);
        checkOutput("a5_valid", {31'd0, word_if.o_word_valid}, 32'd0);
        checkOutput("a5_ferr",  {31'd0, o_frame_err}, 32'd0);
        checkOutput("a5_ovr",   {31'd0, o_overrun}, 32'd0);
        flushPulse();

        $display("[TB] table of bytes at several bit periods");
        for (int i = 0; i < 4; i++) applyStimulus(vecs[i]);
        CLKS_PER_BIT = 8'd10;
        tick(3);
        checkOutput("table_valid_drop", {31'd0, word_if.o_word_valid}, 32'd0);

        $display("[TB] partial word flush then full word");
        sendByte(8'h11);
        sendByte(8'h22);
        flushPulse();
        sendByte(8'hDE);
        sendByte(8'hAD);
        sendByte(8'hBE);
        sendByte(8'hEF);

        $display("[TB] flush with empty accumulator");
        i_flush = 1'b1;
        tick(1);
        i_flush = 1'b0;
        tick(1);
        checkOutput("empty_flush_valid", {31'd0, word_if.o_word_valid}, 32'd0);

        $display("[TB] start glitch");
        i_Rx_Serial = 1'b0;
        tick(3);
        i_Rx_Serial = 1'b1;
        tick(12);
        checkOutput("glitch_active", {31'd0, o_Rx_Active}, 32'd0);
        checkOutput("glitch_ferr",   {31'd0, o_frame_err}, 32'd0);

        $display("[TB] framing error and held break");
        sendFrame(8'h5A, 1'b0, 10);
        tick(50);
        checkOutput("brk_ferr",   {31'd0, o_frame_err}, 32'd1);
        checkOutput("brk_active", {31'd0, o_Rx_Active}, 32'd1);
        i_Rx_Serial = 1'b1;
        tick(5);
        checkOutput("brk_released", {31'd0, o_Rx_Active}, 32'd0);
        sendByte(8'h3C);
        checkOutput("ferr_sticky", {31'd0, o_frame_err}, 32'd1);
        i_err_clr = 1'b1;
        tick(1);
        i_err_clr = 1'b0;
        tick(1);
        checkOutput("ferr_cleared", {31'd0, o_frame_err}, 32'd0);
        flushPulse();

        $display("[TB] error set coincides with clear");
        fork
            sendFrame(8'h77, 1'b0, 10);
            begin
                tick(97);
                i_err_clr = 1'b1;
                tick(1);
                i_err_clr = 1'b0;
            end
        join
        i_Rx_Serial = 1'b1;
        tick(3);
        checkOutput("set_beats_clr", {31'd0, o_frame_err}, 32'd1);
        i_err_clr = 1'b1;
        tick(1);
        i_err_clr = 1'b0;

        $display("[TB] flush on the 4th byte edge");
        sendByte(8'h01);
        sendByte(8'h02);
        sendByte(8'h03);
        modelByte(8'h99);
        fork
            sendFrame(8'h99, 1'b1, 10);
            begin
                tick(97);
                i_flush = 1'b1;
                tick(1);
                i_flush = 1'b0;
            end
        join
        tick(4);

        $display("[TB] overrun");
        word_if.i_word_ready = 1'b0;
        for (int i = 0; i < 8; i++) sendByte(8'(8'hB0 + i));
        void'(exp_words.pop_back());
        checkOutput("ovr_flag",  {31'd0, o_overrun}, 32'd1);
        checkOutput("ovr_valid", {31'd0, word_if.o_word_valid}, 32'd1);
        checkOutput("ovr_held",  word_if.o_word, 32'hB3B2B1B0);
        word_if.i_word_ready = 1'b1;
        tick(2);
        i_err_clr = 1'b1;
        tick(1);
        i_err_clr = 1'b0;
        tick(1);
        checkOutput("ovr_cleared", {31'd0, o_overrun}, 32'd0);

        $display("[TB] ready in the push cycle");
        word_if.i_word_ready = 1'b0;
        for (int i = 0; i < 7; i++) sendByte(8'(8'hC0 + i));
        checkOutput("rdy_held_valid", {31'd0, word_if.o_word_valid}, 32'd1);
        modelByte(8'hC7);
        fork
            sendFrame(8'hC7, 1'b1, 10);
            begin
                tick(97);
                word_if.i_word_ready = 1'b1;
            end
        join
        tick(4);
        checkOutput("rdy_no_overrun", {31'd0, o_overrun}, 32'd0);

        $display("[TB] reset mid-frame");
        word_if.i_word_ready = 1'b0;
        for (int i = 0; i < 5; i++) sendByte(8'(8'hD0 + i));
        i_Rx_Serial = 1'b0;
        tick(10);
        i_Rx_Serial = 1'b1;
        tick(10);
        i_Rx_Serial = 1'b0;
        tick(5);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_active", {31'd0, o_Rx_Active}, 32'd0);
        checkOutput("mid_rst_valid",  {31'd0, word_if.o_word_valid}, 32'd0);
        checkOutput("mid_rst_word",   word_if.o_word, 32'd0);
        checkOutput("mid_rst_byte",   {24'd0, o_Rx_Byte}, 32'd0);
        exp_words.delete();
        m_acc  = '0;
        m_strb = '0;
        m_lane = 0;
        i_Rx_Serial = 1'b1;
        tick(3);
        rst_n = 1'b1;
        word_if.i_word_ready = 1'b1;
        tick(5);
        sendByte(8'h81);
        flushPulse();

        tick(20);
        checkOutput("bytes_left", exp_bytes.size(), 32'd0);
        checkOutput("words_left", exp_words.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_word.md
Name: uart_rx_word

Overview:
- Receive side of the on-chip UART; the counterpart to the existing uart_tx (8N1, LSB first, runtime CLKS_PER_BIT).
- Deserialises the serial line into bytes, then packs bytes little-endian into 32-bit words with a byte strobe.
- Sits beside uart_tx under sp_inter. Gives the cores a host-to-core channel (commands, test vectors) that mirrors the TX word/wstrb path.

Parameters:
- DATA_BITS, 8, data bits per frame (only 8 supported; checked by assertion).
- MIN_CLKS, 4, floor applied to CLKS_PER_BIT.

Ports:
- clk  in  1  system clock (clk_wiz clk_out1).
- rst_n  in  1  reset; asynchronous assert, active-low.
- i_Rx_Serial  in  1  asynchronous serial line; idles high.
- CLKS_PER_BIT  in  8  clocks per bit; same encoding as uart_tx.
- o_Rx_DV  out  1  one-cycle pulse: valid byte received.
- o_Rx_Byte  out  8  last good byte; held until the next good byte.
- o_word  out  32  assembled word; byte0 in bits [7:0].
- o_word_strb  out  4  valid byte lanes of o_word.
- o_word_valid  out  1  word available.
- i_word_ready  in  1  consumer accepts the word.
- i_flush  in  1  push the partial word now.
- o_Rx_Active  out  1  frame in progress (state != IDLE).
- o_frame_err  out  1  sticky: stop bit sampled low.
- o_overrun  out  1  sticky: word dropped because the output register was full.
- i_err_clr  in  1  clears both sticky flags.

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0.
- Line synchroniser:
  - 2-FF synchroniser; its flops reset to 1.
  - All sampling uses the synchronised value rx_s.
- Bit period:
  - cpb = max(CLKS_PER_BIT, MIN_CLKS), latched on the IDLE->START transition.
  - Changes to CLKS_PER_BIT mid-frame are ignored.
- FSM states: IDLE, START, DATA, STOP, BRK_WAIT.
- IDLE: if rx_s==0, go to START and clear clk_cnt.
- START:
  - Count to cpb/2 - 1 (floor), then sample.
  - Sample 0: go to DATA, reset clk_cnt and bit_idx.
  - Sample 1: glitch; return to IDLE with no flags set.
- DATA:
  - Every cpb clocks, shift rx_s into bit position bit_idx.
  - After bit_idx==7 is sampled, go to STOP.
- STOP: after cpb clocks, sample.
  - Sample 1: good byte; o_Rx_DV=1 next cycle, o_Rx_Byte updated; go to IDLE.
  - Sample 0: set o_frame_err, discard the byte, go to BRK_WAIT.
- BRK_WAIT: wait for rx_s==1, then go to IDLE. A held-low break line must not re-trigger frames.
- Word packer:
  - Byte lane counter lane (0..3) and accumulator acc; strb_acc holds the filled lanes.
  - On each good byte, write it to acc[8*lane +: 8] and set strb_acc[lane].
  - When lane==3, or on i_flush with strb_acc!=0, push: o_word=acc (unfilled lanes 0), o_word_strb=strb_acc.
  - After a push, acc, strb_acc and lane are cleared.
  - A push registers on the same edge as o_Rx_DV for the 4th byte.
- Output handshake:
  - o_word_valid rises on a push and holds until the cycle where valid && i_word_ready.
  - o_word and o_word_strb are stable while valid is high.
- Push while o_word_valid && !i_word_ready:
  - Word dropped, o_overrun set, accumulator still cleared.
  - If i_word_ready is high in that same cycle, the push succeeds; no overrun.
- i_flush edge cases:
  - With strb_acc==0: no effect.
  - In the same cycle as a 4th good byte: that byte is included, a single push occurs.
- Sticky flags:
  - i_err_clr clears both flags.
  - A set event in the same cycle as i_err_clr wins (flag stays 1).
- Reset mid-frame: state forced to IDLE; the partial byte, partial word and valid word are all lost.
- Latency: the o_Rx_DV edge falls 9.5 bit periods after the start-bit falling edge at rx_s, plus 2-3 clocks of synchroniser delay.

Decomposition:
- uart_pkg holds uart_rx_state_t (enum), UART_DATA_BITS, UART_MIN_CLKS. uart_tx is migrated to use it.
- Sub-module uart_rx_byte: synchroniser, FSM, produces o_Rx_DV/o_Rx_Byte/frame_err pulse.
- uart_rx_word is the packer plus flags, wrapping uart_rx_byte.

Test Plan:
- CLKS_PER_BIT=10; send 0xA5 -> one o_Rx_DV pulse, o_Rx_Byte=0xA5, no flags, o_word_valid stays 0.
- Send 0x11,0x22,0x33,0x44 with ready=1 -> o_word=0x44332211, strb=4'hF, valid for 1 cycle.
- Send 0x11,0x22, then pulse i_flush -> o_word=0x00002211, strb=4'b0011. Next 4 bytes start at lane 0.
- Low glitch of 3 clocks (< cpb/2) -> no DV, state back to IDLE, no o_frame_err.
- Frame 0x5A with stop bit low, line held low 50 clocks -> o_frame_err=1, no DV, no re-trigger until high. Next good byte 0x3C is received; i_err_clr clears the flag.
- ready=0; send 8 bytes -> first word held, second dropped, o_overrun=1. Ready in the push cycle of the 8th byte -> no overrun.
- rst_n low mid-DATA -> all outputs 0 immediately. Next clean frame 0x81 is received correctly.
